logic_combiner_pipe: RTL and testbench
======================================

Name: logic_combiner_pipe

Overview:
Parametrised, pipelined successor to the team's 3-input single-bit logic combiner. It reduces NUM_IN input vectors of WIDTH bits each into one WIDTH-bit result, using a per-beat selectable bitwise operation. Inputs and outputs use valid/ready handshakes with full backpressure. It also produces a parity bit, an illegal-mode flag, and a saturating transfer counter. The block sits between a producer stage and a consumer stage in the datapath.

Parameters:
WIDTH, 8, bit width of each input vector and of the result
NUM_IN, 3, number of input vectors combined (legal range 2..16)
CNT_W, 16, width of op_count

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept an input beat
in_data  input  NUM_IN*WIDTH  packed vectors; vector k is in_data[k*WIDTH +: WIDTH]
in_mode  input  3  operation for this beat, captured together with in_data
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  combined result
out_parity  output  1  XOR-reduction of out_data
out_err  output  1  this beat carried an illegal mode
clr_count  input  1  synchronous clear of op_count
op_count  output  CNT_W  number of completed output transfers, saturating

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_parity=0, out_err=0, op_count=0. in_ready is forced 0 while rst_n is low. Any beats in flight are discarded.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Pipeline stage s1: registers in_data and in_mode.
- Pipeline stage s2: computes the result from the s1 contents and registers out_data, out_parity and out_err. out_valid = s2_valid.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 beat per cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- Hold rule: while out_valid && !out_ready, out_data, out_parity and out_err must stay stable.
- Modes, all applied bitwise across the NUM_IN vectors:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 MAJ: result bit = 1 iff the number of 1s in that bit position > NUM_IN/2 (integer division), i.e. strict majority. For even NUM_IN, a tie gives 0.
  - 4 NAND
  - 5 NOR
  - 6 XNOR (inverted XOR)
  - 7 illegal: out_data=0, out_err=1. All other modes give out_err=0.
- Parity: out_parity = ^out_data (1 when the count of ones is odd). It is registered with the data.
- op_count:
  - Increments by 1 on each output transfer.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_count sets it to 0 on the next edge. If clr_count coincides with a transfer, clear wins and the result is 0.
- Ordering: beats leave in acceptance order, with no loss and no duplication.
- in_mode and in_data are ignored when in_valid=0.
- Reset mid-operation: all state clears immediately. After rst_n rises, no stale beat appears on the output.

Test Plan:
WIDTH=8, NUM_IN=3 unless noted; vectors are listed as {v0,v1,v2}.
1. AND: in {0xF0,0xCC,0xAA} mode 0, out_ready=1 -> out_valid 2 cycles after acceptance; out_data=0x80, out_parity=1, out_err=0.
2. XOR and MAJ back-to-back: same vectors, mode 2 then mode 3 on consecutive cycles -> out_data=0x96 (parity 0), then 0xE8 (parity 0), on consecutive cycles.
3. Backpressure:
   - Stimulus: out_ready=0 for 6 cycles while presenting 4 distinct beats continuously.
   - While stalled: only 2 beats are accepted, then in_ready=0; out_data is held constant.
   - After out_ready=1: all 4 results emerge in order, with no gaps after the first.
4. Illegal mode: in {0xFF,0xFF,0xFF} mode 7 -> out_data=0x00, out_err=1, out_parity=0. The next beat in mode 1 -> out_data=0xFF, out_err=0.
5. Counter (CNT_W=4):
   - 20 transfers -> op_count=15 (saturated).
   - clr_count asserted in the same cycle as a transfer -> op_count=0.
   - 1 further transfer -> op_count=1.
6. Reset mid-flight:
   - Stimulus: 2 beats accepted, out_ready=0, then rst_n driven low asynchronously between edges.
   - Required: out_valid=0 and op_count=0 immediately; in_ready=0 while rst_n is low.
   - After release: in_ready=1, and no result appears until new input is accepted.

Source files
------------

// File: rtl/logic_combiner_pipe.sv
// -----------------------------------------------------------------------------
// logic_combiner_pipe
//
// Two-stage pipelined bitwise combiner. NUM_IN vectors of WIDTH bits arrive
// packed on in_data and are reduced into one WIDTH-bit result. The operation
// (AND/OR/XOR/MAJ/NAND/NOR/XNOR) is chosen per beat by in_mode. Mode 7 is
// illegal and yields a zero result with out_err set. Both sides use
// valid/ready handshakes with full backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready forced low during reset)
//   in_data             packed vectors, vector k = in_data[k*WIDTH +: WIDTH]
//   in_mode             operation for this beat
//   out_valid/out_ready output handshake
//   out_data            combined result
//   out_parity          XOR-reduction of out_data
//   out_err             beat carried the illegal mode
//   clr_count           synchronous clear of op_count (wins over increment)
//   op_count            saturating count of completed output transfers
//
// NUM_IN is intended to lie in 2..16.
// -----------------------------------------------------------------------------
module logic_combiner_pipe #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 3,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [2:0]              in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_parity,
   output logic                    out_err,
   input  logic                    clr_count,
   output logic [CNT_W-1:0]        op_count
);

   typedef enum logic [2:0] {
      MODE_AND  = 3'd0,
      MODE_OR   = 3'd1,
      MODE_XOR  = 3'd2,
      MODE_MAJ  = 3'd3,
      MODE_NAND = 3'd4,
      MODE_NOR  = 3'd5,
      MODE_XNOR = 3'd6,
      MODE_ILL  = 3'd7
   } mode_e;

   // Stage 1 registers
   logic                    r_s1_valid;
   logic [NUM_IN*WIDTH-1:0] r_s1_data;
   mode_e                   r_s1_mode;

   // Stage 2 (output) registers
   logic                    r_s2_valid;
   logic [WIDTH-1:0]        r_out_data;
   logic                    r_out_parity;
   logic                    r_out_err;
   logic [CNT_W-1:0]        r_op_count;

   logic                    w_s2_adv;
   logic                    w_s1_adv;
   logic                    w_in_xfer;
   logic                    w_out_xfer;
   logic [WIDTH-1:0]        w_result;
   logic                    w_err;

   // Bitwise reduction of all vectors for the selected mode.
   function automatic logic [WIDTH-1:0] f_combine(
      input logic [NUM_IN*WIDTH-1:0] data,
      input mode_e                   mode
   );
      logic [WIDTH-1:0] v_and;
      logic [WIDTH-1:0] v_or;
      logic [WIDTH-1:0] v_xor;
      logic [WIDTH-1:0] v_maj;
      logic [WIDTH-1:0] v_res;
      int               ones;
      v_and = '1;
      v_or  = '0;
      v_xor = '0;
      v_maj = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         v_and = v_and & data[k*WIDTH +: WIDTH];
         v_or  = v_or  | data[k*WIDTH +: WIDTH];
         v_xor = v_xor ^ data[k*WIDTH +: WIDTH];
      end
      // Strict majority: with an even NUM_IN a tie resolves to 0.
      for (int b = 0; b < WIDTH; b++) begin
         ones = 0;
         for (int k = 0; k < NUM_IN; k++) begin
            ones = ones + int'(data[k*WIDTH + b]);
         end
         v_maj[b] = (ones > NUM_IN / 2);
      end
      case (mode)
         MODE_AND:  v_res = v_and;
         MODE_OR:   v_res = v_or;
         MODE_XOR:  v_res = v_xor;
         MODE_MAJ:  v_res = v_maj;
         MODE_NAND: v_res = ~v_and;
         MODE_NOR:  v_res = ~v_or;
         MODE_XNOR: v_res = ~v_xor;
         default:   v_res = '0;
      endcase
      return v_res;
   endfunction

   // Each stage moves when its downstream slot is empty or being drained.
   // in_ready is therefore combinational from out_ready (no skid buffer).
   assign w_s2_adv   = !r_s2_valid || out_ready;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign in_ready   = rst_n && w_s1_adv;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_s2_valid && out_ready;

   // NOTE: every variable assigned in always_comb gets a value on every path
   // (here a single unconditional assignment each), so no latch is inferred.
   always_comb begin
      w_result = f_combine(r_s1_data, r_s1_mode);
      w_err    = (r_s1_mode == MODE_ILL);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   // NOTE: datapath registers are reset as well, so out_data/out_parity/
   // out_err read 0 after reset and nothing stale can leak out later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_mode  <= MODE_AND;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (w_in_xfer) begin
            r_s1_data <= in_data;
            r_s1_mode <= mode_e'(in_mode);
         end
      end
   end

   // Output registers only change when a new beat moves in, which keeps them
   // stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid   <= 1'b0;
         r_out_data   <= '0;
         r_out_parity <= 1'b0;
         r_out_err    <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data   <= w_result;
            r_out_parity <= ^w_result;
            r_out_err    <= w_err;
         end
      end
   end

   // Saturating transfer counter; clear has priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (clr_count) begin
         r_op_count <= '0;
      end else if (w_out_xfer && (r_op_count != {CNT_W{1'b1}})) begin
         r_op_count <= r_op_count + 1'b1;
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_data   = r_out_data;
   assign out_parity = r_out_parity;
   assign out_err    = r_out_err;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_logic_combiner_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_combiner_pipe
//
// Directed bench for logic_combiner_pipe (WIDTH=8, NUM_IN=3, CNT_W=4).
// Accepted beats are modelled into a scoreboard queue and popped when the
// DUT completes an output transfer; directed checks cover latency, stall
// behaviour, illegal mode, counter saturation/clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_logic_combiner_pipe;

   localparam int WIDTH  = 8;
   localparam int NUM_IN = 3;
   localparam int CNT_W  = 4;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             p;
      logic             e;
   } exp_t;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [2:0]              in_mode;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_parity;
   logic                    out_err;
   logic                    clr_count;
   logic [CNT_W-1:0]        op_count;

   int   errors;
   int   checks;
   exp_t q[$];
   logic prev_stall;
   exp_t held;

   logic_combiner_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_parity (out_parity),
      .out_err    (out_err),
      .clr_count  (clr_count),
      .op_count   (op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour, column by column across the three vectors.
   function automatic exp_t model(input logic [NUM_IN*WIDTH-1:0] d, input logic [2:0] m);
      exp_t       r;
      logic [2:0] col;
      r.d = '0;
      r.e = (m == 3'd7);
      for (int b = 0; b < WIDTH; b++) begin
         col = {d[2*WIDTH+b], d[WIDTH+b], d[b]};
         case (m)
            3'd0:    r.d[b] = (col == 3'b111);
            3'd1:    r.d[b] = (col != 3'b000);
            3'd2:    r.d[b] = ($countones(col) % 2) == 1;
            3'd3:    r.d[b] = ($countones(col) >= 2);
            3'd4:    r.d[b] = (col != 3'b111);
            3'd5:    r.d[b] = (col == 3'b000);
            3'd6:    r.d[b] = ($countones(col) % 2) == 0;
            default: r.d[b] = 1'b0;
         endcase
      end
      r.p = ($countones(r.d) % 2) == 1;
      return r;
   endfunction

   // One clock: sample/score on the falling edge, return just after the
   // rising edge so the caller can drive the next cycle's inputs.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (rst_n) begin
         if (prev_stall) begin
            check("hold_valid",  32'(out_valid),  32'(1'b1));
            check("hold_data",   32'(out_data),   32'(held.d));
            check("hold_parity", 32'(out_parity), 32'(held.p));
            check("hold_err",    32'(out_err),    32'(held.e));
         end
         if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
         if (out_valid && q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'(1'b0));
         end else if (out_valid && out_ready) begin
            e = q.pop_front();
            check("sb_data",   32'(out_data),   32'(e.d));
            check("sb_parity", 32'(out_parity), 32'(e.p));
            check("sb_err",    32'(out_err),    32'(e.e));
         end
         prev_stall = out_valid && !out_ready;
         held.d     = out_data;
         held.p     = out_parity;
         held.e     = out_err;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                        input logic [2:0] m);
      in_valid = 1'b1;
      in_data  = {v2, v1, v0};
      in_mode  = m;
   endtask

   logic [NUM_IN*WIDTH-1:0] bp_data [4];
   logic [2:0]              bp_mode [4];
   int                      idx;
   int                      accepted;
   int                      got;
   logic                    gap;

   initial begin
      errors     = 0;
      checks     = 0;
      prev_stall = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_mode    = '0;
      out_ready  = 1'b0;
      clr_count  = 1'b0;

      // Reset state
      #3;
      check("rst_out_valid", 32'(out_valid), 32'(1'b0));
      check("rst_in_ready",  32'(in_ready),  32'(1'b0));
      check("rst_out_data",  32'(out_data),  32'(8'h00));
      check("rst_op_count",  32'(op_count),  32'(4'd0));
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'(1'b1));

      // 1. AND with 2-cycle latency
      out_ready = 1'b1;
      drive(8'hF0, 8'hCC, 8'hAA, 3'd0);
      step();
      in_valid = 1'b0;
      step();
      check("and_valid",  32'(out_valid),  32'(1'b1));
      check("and_data",   32'(out_data),   32'(8'h80));
      check("and_parity", 32'(out_parity), 32'(1'b1));
      check("and_err",    32'(out_err),    32'(1'b0));
      step();

      // 2. XOR then MAJ back to back
      drive(8'hF0, 8'hCC, 8'hAA, 3'd2);
      step();
      drive(8'hF0, 8'hCC, 8'hAA, 3'd3);
      step();
      in_valid = 1'b0;
      check("xor_data",   32'(out_data),   32'(8'h96));
      check("xor_parity", 32'(out_parity), 32'(1'b0));
      step();
      check("maj_valid",  32'(out_valid),  32'(1'b1));
      check("maj_data",   32'(out_data),   32'(8'hE8));
      check("maj_parity", 32'(out_parity), 32'(1'b0));
      step();

      // 3. Backpressure: 6 stalled cycles with 4 beats on offer
      bp_data[0] = 24'h33_22_11; bp_mode[0] = 3'd1;
      bp_data[1] = 24'h0F_5A_C3; bp_mode[1] = 3'd2;
      bp_data[2] = 24'hFF_81_7E; bp_mode[2] = 3'd4;
      bp_data[3] = 24'h13_37_A5; bp_mode[3] = 3'd6;
      out_ready = 1'b0;
      #1;
      idx      = 0;
      accepted = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = bp_data[idx];
         in_mode  = bp_mode[idx];
         if (in_ready) begin
            idx++;
            accepted++;
         end
         step();
      end
      check("bp_accepted", 32'(accepted), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'(1'b0));
      out_ready = 1'b1;
      #1;
      got = 0;
      gap = 1'b0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (idx < 4) begin
            in_valid = 1'b1;
            in_data  = bp_data[idx];
            in_mode  = bp_mode[idx];
            if (in_ready) idx++;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) got++;
         else if (got > 0) gap = 1'b1;
         step();
      end
      in_valid = 1'b0;
      check("bp_outputs", 32'(got), 32'd4);
      check("bp_no_gap",  32'(gap), 32'(1'b0));

      // 4. Illegal mode, then a legal OR
      drive(8'hFF, 8'hFF, 8'hFF, 3'd7);
      step();
      drive(8'hFF, 8'hFF, 8'hFF, 3'd1);
      step();
      in_valid = 1'b0;
      check("ill_data",   32'(out_data),   32'(8'h00));
      check("ill_err",    32'(out_err),    32'(1'b1));
      check("ill_parity", 32'(out_parity), 32'(1'b0));
      step();
      check("or_data", 32'(out_data), 32'(8'hFF));
      check("or_err",  32'(out_err),  32'(1'b0));
      step();

      // 5. Counter saturation and clear priority
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      check("cnt_cleared", 32'(op_count), 32'd0);
      for (int c = 0; c < 20; c++) begin
         drive(8'(c), 8'(c * 3), 8'(c * 7), 3'(c % 7));
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("cnt_saturated", 32'(op_count), 32'd15);
      drive(8'h12, 8'h34, 8'h56, 3'd5);
      step();
      in_valid = 1'b0;
      step();
      check("cnt_clr_valid", 32'(out_valid), 32'(1'b1));
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      check("cnt_clr_wins", 32'(op_count), 32'd0);
      drive(8'h9A, 8'hBC, 8'hDE, 3'd3);
      step();
      in_valid = 1'b0;
      step();
      step();
      check("cnt_one", 32'(op_count), 32'd1);

      // 6. Asynchronous reset with beats in flight
      out_ready = 1'b0;
      drive(8'h01, 8'h02, 8'h03, 3'd1);
      step();
      drive(8'h04, 8'h05, 8'h06, 3'd2);
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'(1'b0));
      check("arst_op_count",  32'(op_count),  32'd0);
      check("arst_in_ready",  32'(in_ready),  32'(1'b0));
      q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check("arst_rel_in_ready", 32'(in_ready), 32'(1'b1));
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) step();
      check("arst_no_stale", 32'(out_valid), 32'(1'b0));
      drive(8'h3C, 8'hC3, 8'h55, 3'd6);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 10 && q.size() > 0; c++) step();
      check("final_drain", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
